// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle processor control path.
package proc_pkg;

   localparam logic [2:0] OP_LI   = 3'b000;
   localparam logic [2:0] OP_LW   = 3'b001;
   localparam logic [2:0] OP_SW   = 3'b010;
   localparam logic [2:0] OP_ADDI = 3'b011;
   localparam logic [2:0] OP_BEQ  = 3'b100;
   localparam logic [2:0] OP_SLTI = 3'b101;
   localparam logic [2:0] OP_ADD  = 3'b110;
   localparam logic [2:0] OP_JMP  = 3'b111;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_SLT   = 2'b10;
   localparam logic [1:0] ALU_UPPER = 2'b11;

   localparam logic [1:0] PC_INC    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXEC_ALU  = 3'd2,
      ST_EXEC_ADDR = 3'd3,
      ST_MEM       = 3'd4,
      ST_WB        = 3'd5,
      ST_BRANCH    = 3'd6,
      ST_JUMP      = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      CLS_NOP,
      CLS_ALU,
      CLS_MEM,
      CLS_BRANCH,
      CLS_JUMP
   } op_class_t;

   // Execute-stage fields derived from the opcode alone.
   typedef struct packed {
      op_class_t  op_class;
      logic       is_li;
      logic       is_sw;
      logic       alu_src;
      logic [1:0] alu_ctrl;
      logic       m_sel;
   } exec_fields_t;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode map to instruction class and execute-stage fields.
module opcode_decode
   import proc_pkg::*;
#(
   parameter int OPC_W = 3
) (
   input  logic [OPC_W-1:0] i_opcode,
   input  logic             i_li_phase,
   output exec_fields_t     o_fields
);

   // Opcodes outside the 3-bit encoding space fall through to NOP.
   always_comb begin
      o_fields          = '0;
      o_fields.op_class = CLS_NOP;
      case (i_opcode)
         OPC_W'(OP_LI): begin
            o_fields.op_class = CLS_ALU;
            o_fields.is_li    = 1'b1;
            o_fields.alu_src  = 1'b1;
            o_fields.m_sel    = 1'b1;
            o_fields.alu_ctrl = i_li_phase ? ALU_ADD : ALU_UPPER;
         end
         OPC_W'(OP_ADDI): begin
            o_fields.op_class = CLS_ALU;
            o_fields.alu_src  = 1'b1;
            o_fields.alu_ctrl = ALU_ADD;
         end
         OPC_W'(OP_SLTI): begin
            o_fields.op_class = CLS_ALU;
            o_fields.alu_src  = 1'b1;
            o_fields.alu_ctrl = ALU_SLT;
         end
         OPC_W'(OP_ADD): begin
            o_fields.op_class = CLS_ALU;
            o_fields.alu_ctrl = ALU_ADD;
         end
         OPC_W'(OP_LW): begin
            o_fields.op_class = CLS_MEM;
            o_fields.alu_src  = 1'b1;
            o_fields.alu_ctrl = ALU_ADD;
         end
         OPC_W'(OP_SW): begin
            o_fields.op_class = CLS_MEM;
            o_fields.is_sw    = 1'b1;
            o_fields.alu_src  = 1'b1;
            o_fields.alu_ctrl = ALU_ADD;
         end
         OPC_W'(OP_BEQ): begin
            o_fields.op_class = CLS_BRANCH;
            o_fields.alu_ctrl = ALU_SUB;
         end
         OPC_W'(OP_JMP): begin
            o_fields.op_class = CLS_JUMP;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 8-bit processor.
//
//  state      | meaning
//  -----------+-------------------------------------------------------
//  FETCH      | read instruction at PC; on ack load IR and bump PC
//  DECODE     | single idle cycle; branch on opcode class
//  EXEC_ALU   | li/addi/slti/add execute and write back
//  EXEC_ADDR  | compute lw/sw effective address
//  MEM        | data access at ALU result; hold until ack
//  WB         | lw writes memory data to register file
//  BRANCH     | beq compare; PC takes branch target if zero
//  JUMP       | PC takes jump target
module multicycle_ctrl
   import proc_pkg::*;
#(
   parameter int INSTR_W    = 8,
   parameter int OPC_W      = 3,
   parameter int ALU_CTRL_W = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [INSTR_W-1:0]    instr,
   input  logic                  alu_zero,
   input  logic                  mem_ack,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic                  iord,
   output logic                  ir_write,
   output logic                  pc_en,
   output logic [1:0]            pc_src,
   output logic                  alu_src,
   output logic [ALU_CTRL_W-1:0] alu_ctrl,
   output logic                  m_sel,
   output logic                  mem_to_reg,
   output logic                  reg_write,
   output logic                  li_phase,
   output logic                  instr_done,
   output logic [2:0]            state_dbg
);

   state_t       r_state;
   state_t       w_state_next;
   logic         r_li_phase;
   exec_fields_t w_fields;
   logic [OPC_W-1:0] w_opcode;

   assign w_opcode = instr[INSTR_W-1 -: OPC_W];

   generate
      if (INSTR_W > OPC_W) begin : g_operand_bits
         // Operand bits are consumed by the datapath, not by control.
         logic w_unused_instr;
         assign w_unused_instr = ^instr[INSTR_W-OPC_W-1:0];
      end
   endgenerate

   opcode_decode #(
      .OPC_W (OPC_W)
   ) u_opcode_decode (
      .i_opcode   (w_opcode),
      .i_li_phase (r_li_phase),
      .o_fields   (w_fields)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   // li upper/lower phase flips only when an li retires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_li_phase <= 1'b0;
      end else if (r_state == ST_EXEC_ALU && w_fields.is_li) begin
         r_li_phase <= ~r_li_phase;
      end
   end

   // Next-state and control outputs; everything is forced low while reset
   // is asserted so an in-flight memory request drops immediately.
   always_comb begin
      w_state_next = r_state;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      iord         = 1'b0;
      ir_write     = 1'b0;
      pc_en        = 1'b0;
      pc_src       = PC_INC;
      alu_src      = 1'b0;
      alu_ctrl     = '0;
      m_sel        = 1'b0;
      mem_to_reg   = 1'b0;
      reg_write    = 1'b0;
      instr_done   = 1'b0;
      if (rst_n) begin
         case (r_state)
            ST_FETCH: begin
               mem_req = 1'b1;
               if (mem_ack) begin
                  ir_write     = 1'b1;
                  pc_en        = 1'b1;
                  w_state_next = ST_DECODE;
               end
            end
            ST_DECODE: begin
               case (w_fields.op_class)
                  CLS_ALU:    w_state_next = ST_EXEC_ALU;
                  CLS_MEM:    w_state_next = ST_EXEC_ADDR;
                  CLS_BRANCH: w_state_next = ST_BRANCH;
                  CLS_JUMP:   w_state_next = ST_JUMP;
                  default: begin
                     instr_done   = 1'b1;
                     w_state_next = ST_FETCH;
                  end
               endcase
            end
            ST_EXEC_ALU: begin
               alu_src      = w_fields.alu_src;
               alu_ctrl     = ALU_CTRL_W'(w_fields.alu_ctrl);
               m_sel        = w_fields.m_sel;
               reg_write    = 1'b1;
               instr_done   = 1'b1;
               w_state_next = ST_FETCH;
            end
            ST_EXEC_ADDR: begin
               alu_src      = 1'b1;
               alu_ctrl     = ALU_CTRL_W'(ALU_ADD);
               w_state_next = ST_MEM;
            end
            ST_MEM: begin
               alu_src  = 1'b1;
               alu_ctrl = ALU_CTRL_W'(ALU_ADD);
               mem_req  = 1'b1;
               iord     = 1'b1;
               mem_we   = w_fields.is_sw;
               if (mem_ack) begin
                  if (w_fields.is_sw) begin
                     instr_done   = 1'b1;
                     w_state_next = ST_FETCH;
                  end else begin
                     w_state_next = ST_WB;
                  end
               end
            end
            ST_WB: begin
               reg_write    = 1'b1;
               mem_to_reg   = 1'b1;
               instr_done   = 1'b1;
               w_state_next = ST_FETCH;
            end
            ST_BRANCH: begin
               alu_ctrl     = ALU_CTRL_W'(ALU_SUB);
               pc_src       = PC_BRANCH;
               pc_en        = alu_zero;
               instr_done   = 1'b1;
               w_state_next = ST_FETCH;
            end
            ST_JUMP: begin
               pc_en        = 1'b1;
               pc_src       = PC_JUMP;
               instr_done   = 1'b1;
               w_state_next = ST_FETCH;
            end
            default: w_state_next = ST_FETCH;
         endcase
      end
   end

   assign li_phase  = r_li_phase;
   assign state_dbg = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes the expected
// retirement snapshot, a negedge monitor pops it on each instr_done.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] instr;
   logic       alu_zero;
   logic       mem_ack;
   logic       mem_req, mem_we, iord, ir_write, pc_en;
   logic [1:0] pc_src;
   logic       alu_src;
   logic [1:0] alu_ctrl;
   logic       m_sel, mem_to_reg, reg_write, li_phase, instr_done;
   logic [2:0] state_dbg;
   logic [17:0] w_obs;

   multicycle_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .instr      (instr),
      .alu_zero   (alu_zero),
      .mem_ack    (mem_ack),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .iord       (iord),
      .ir_write   (ir_write),
      .pc_en      (pc_en),
      .pc_src     (pc_src),
      .alu_src    (alu_src),
      .alu_ctrl   (alu_ctrl),
      .m_sel      (m_sel),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .li_phase   (li_phase),
      .instr_done (instr_done),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   assign w_obs = {mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src,
                   alu_ctrl, m_sel, mem_to_reg, reg_write, li_phase,
                   instr_done, state_dbg};

   typedef struct {
      logic [17:0] vec;
      int          cycles;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   function automatic logic [17:0] mk(
      input logic mreq, input logic mwe, input logic io, input logic irw,
      input logic pce, input logic [1:0] pcs, input logic asrc,
      input logic [1:0] actl, input logic msel, input logic m2r,
      input logic rw, input logic lip, input logic dn, input logic [2:0] st);
      return {mreq, mwe, io, irw, pce, pcs, asrc, actl, msel, m2r, rw, lip, dn, st};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Monitor: count cycles per instruction and compare at retirement.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         cyc = 0;
      end else begin
         cyc++;
         if (instr_done === 1'b1) begin
            check("sb_nonempty_at_done", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check({e.name, "_done_vec"}, 32'(w_obs), 32'(e.vec));
               check({e.name, "_cycles"}, 32'(cyc), 32'(e.cycles));
            end
            cyc = 0;
         end
      end
   end

   // Called just after the edge that enters FETCH; returns just after the
   // edge that follows the instruction's final cycle.
   task automatic do_instr(input string name, input logic [7:0] ins,
                           input int waits, input logic zero, input logic exp_we,
                           input logic [17:0] exp_vec, input int exp_cycles);
      exp_t e;
      bit   done;
      int   w;
      e.vec = exp_vec; e.cycles = exp_cycles; e.name = name;
      sb.push_back(e);
      instr    = ins;
      alu_zero = zero;
      done     = 1'b0;
      w        = waits;
      for (int n = 0; n < 30 && !done; n++) begin
         if (state_dbg == 3'd4 && w > 0) begin
            mem_ack = 1'b0;
            w--;
            #1;
            check({name, "_memwait"}, 32'({mem_req, iord, mem_we, ir_write}),
                  32'({1'b1, 1'b1, exp_we, 1'b0}));
         end else begin
            mem_ack = 1'b1;
            #1;
            if (state_dbg == 3'd0)
               check({name, "_fetch"}, 32'({mem_req, mem_we, iord, ir_write, pc_en, pc_src}),
                     32'(7'b1_0_0_1_1_00));
            else if (state_dbg != 3'd4)
               check({name, "_noreq"}, 32'(mem_req), 32'd0);
         end
         done = instr_done;
         @(posedge clk); #1;
      end
      check({name, "_timeout"}, 32'(done), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; mem_ack = 1'b1; instr = 8'h00; alu_zero = 1'b0;
      #2;
      check("reset_outputs", 32'(w_obs), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      do_instr("addi", 8'h61, 0, 1'b0, 1'b0,
               mk(0,0,0,0,0,2'b00,1,2'b00,0,0,1,0,1,3'd2), 3);
      do_instr("li_upper", 8'h05, 0, 1'b0, 1'b0,
               mk(0,0,0,0,0,2'b00,1,2'b11,1,0,1,0,1,3'd2), 3);
      check("li_phase_after_first", 32'(li_phase), 32'd1);
      do_instr("li_lower", 8'h0A, 0, 1'b0, 1'b0,
               mk(0,0,0,0,0,2'b00,1,2'b00,1,0,1,1,1,3'd2), 3);
      check("li_phase_after_second", 32'(li_phase), 32'd0);
      do_instr("lw_wait2", 8'h25, 2, 1'b0, 1'b0,
               mk(0,0,0,0,0,2'b00,0,2'b00,0,1,1,0,1,3'd5), 7);
      do_instr("beq_taken", 8'h80, 0, 1'b1, 1'b0,
               mk(0,0,0,0,1,2'b01,0,2'b01,0,0,0,0,1,3'd6), 3);
      do_instr("beq_not_taken", 8'h80, 0, 1'b0, 1'b0,
               mk(0,0,0,0,0,2'b01,0,2'b01,0,0,0,0,1,3'd6), 3);
      do_instr("jump", 8'hE3, 0, 1'b0, 1'b0,
               mk(0,0,0,0,1,2'b10,0,2'b00,0,0,0,0,1,3'd7), 3);
      do_instr("sw", 8'h45, 0, 1'b0, 1'b1,
               mk(1,1,1,0,0,2'b00,1,2'b00,0,0,0,0,1,3'd4), 4);
      do_instr("sw_wait1", 8'h45, 1, 1'b0, 1'b1,
               mk(1,1,1,0,0,2'b00,1,2'b00,0,0,0,0,1,3'd4), 5);
      do_instr("slti", 8'hA7, 0, 1'b0, 1'b0,
               mk(0,0,0,0,0,2'b00,1,2'b10,0,0,1,0,1,3'd2), 3);
      do_instr("add", 8'hC1, 0, 1'b0, 1'b0,
               mk(0,0,0,0,0,2'b00,0,2'b00,0,0,1,0,1,3'd2), 3);
      do_instr("li_pre_reset", 8'h07, 0, 1'b0, 1'b0,
               mk(0,0,0,0,0,2'b00,1,2'b11,1,0,1,0,1,3'd2), 3);
      check("li_phase_mid_pair", 32'(li_phase), 32'd1);

      // sw abandoned by reset while waiting in MEM.
      instr = 8'h45; mem_ack = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      #1;
      check("sw_mem_before_reset", 32'({state_dbg, mem_req, mem_we, iord}),
            32'({3'd4, 1'b1, 1'b1, 1'b1}));
      @(posedge clk); #2;
      rst_n   = 1'b0;
      mem_ack = 1'b1;
      #1;
      check("reset_mid_sw_outputs", 32'(w_obs), 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      #1;
      check("fetch_after_reset", 32'({state_dbg, mem_req, mem_we, iord}),
            32'({3'd0, 1'b1, 1'b0, 1'b0}));
      do_instr("li_after_reset", 8'h05, 0, 1'b0, 1'b0,
               mk(0,0,0,0,0,2'b00,1,2'b11,1,0,1,0,1,3'd2), 3);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
